// File: rtl/reg_file_wb.sv
`default_nettype none
// reg_file_wb: 8x8 register file with a one-deep write-back stage that forwards to both read ports.
// Revision 1.0
module reg_file_wb #(
   parameter int NREGS = 8,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] IN,
   input  logic [AW-1:0]    INADDRESS,
   input  logic             WRITEENABLE,
   input  logic             ZERO_IN,
   input  logic [AW-1:0]    OUT1ADDRESS,
   input  logic [AW-1:0]    OUT2ADDRESS,
   output logic [WIDTH-1:0] REGOUT1,
   output logic [WIDTH-1:0] REGOUT2,
   output logic             WB_VALID,
   output logic             ZERO_FLAG
);

   logic [WIDTH-1:0] regs_q [NREGS];
   logic             wb_valid_q, wb_valid_d;
   logic [AW-1:0]    wb_addr_q,  wb_addr_d;
   logic [WIDTH-1:0] wb_data_q,  wb_data_d;
   logic             zero_flag_q, zero_flag_d;

   // Only the valid bit tracks WRITEENABLE every cycle; payload and flag hold when idle.
   always_comb begin
      wb_valid_d  = WRITEENABLE;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
      zero_flag_d = zero_flag_q;
      if (WRITEENABLE) begin
         wb_addr_d   = INADDRESS;
         wb_data_d   = IN;
         zero_flag_d = ZERO_IN;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         wb_valid_q  <= 1'b0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
         zero_flag_q <= 1'b0;
      end else begin
         if (wb_valid_q) regs_q[wb_addr_q] <= wb_data_q;
         wb_valid_q  <= wb_valid_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
         zero_flag_q <= zero_flag_d;
      end
   end

   // Forward only from the staged write, never from IN, to avoid a loop through the ALU.
   assign REGOUT1 = (wb_valid_q && (wb_addr_q == OUT1ADDRESS)) ? wb_data_q : regs_q[OUT1ADDRESS];
   assign REGOUT2 = (wb_valid_q && (wb_addr_q == OUT2ADDRESS)) ? wb_data_q : regs_q[OUT2ADDRESS];

   assign WB_VALID  = wb_valid_q;
   assign ZERO_FLAG = zero_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// tb_reg_file_wb: directed plus randomized checks of reg_file_wb against an architectural model.
// Revision 1.0
module tb_reg_file_wb;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [7:0] IN;
   logic [2:0] INADDRESS;
   logic       WRITEENABLE;
   logic       ZERO_IN;
   logic [2:0] OUT1ADDRESS;
   logic [2:0] OUT2ADDRESS;
   logic [7:0] REGOUT1;
   logic [7:0] REGOUT2;
   logic       WB_VALID;
   logic       ZERO_FLAG;

   int n_tests = 0;
   int n_fail  = 0;

   // Architectural view: a read returns the last value written to that address.
   logic [7:0] arch [8];
   logic       exp_wbv;
   logic       exp_zf;

   reg_file_wb dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .IN          (IN),
      .INADDRESS   (INADDRESS),
      .WRITEENABLE (WRITEENABLE),
      .ZERO_IN     (ZERO_IN),
      .OUT1ADDRESS (OUT1ADDRESS),
      .OUT2ADDRESS (OUT2ADDRESS),
      .REGOUT1     (REGOUT1),
      .REGOUT2     (REGOUT2),
      .WB_VALID    (WB_VALID),
      .ZERO_FLAG   (ZERO_FLAG)
   );

   always #20 CLK = ~CLK;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) arch[i] = 8'h00;
      exp_wbv = 1'b0;
      exp_zf  = 1'b0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ":REGOUT1"}, REGOUT1, arch[OUT1ADDRESS]);
      chk({tag, ":REGOUT2"}, REGOUT2, arch[OUT2ADDRESS]);
      chk({tag, ":WB_VALID"}, {7'd0, WB_VALID}, {7'd0, exp_wbv});
      chk({tag, ":ZERO_FLAG"}, {7'd0, ZERO_FLAG}, {7'd0, exp_zf});
   endtask

   // Called just after a falling edge; finishes on the next falling edge after checking.
   task automatic cycle(input string tag, input logic we, input logic [2:0] wa,
                        input logic [7:0] wd, input logic z,
                        input logic [2:0] r1, input logic [2:0] r2);
      WRITEENABLE = we;
      ZERO_IN     = z;
      INADDRESS   = we ? wa : 3'bx;
      IN          = we ? wd : 8'bx;
      OUT1ADDRESS = r1;
      OUT2ADDRESS = r2;
      @(posedge CLK);
      if (RESET_N) begin
         exp_wbv = we;
         if (we) begin
            arch[wa] = wd;
            exp_zf   = z;
         end
      end
      @(negedge CLK);
      #1;
      check_state(tag);
   endtask

   // Sweep all addresses on both ports within the low half of the clock.
   task automatic sweep(input string tag);
      for (int a = 0; a < 8; a++) begin
         OUT1ADDRESS = 3'(a);
         OUT2ADDRESS = 3'(7 - a);
         #1;
         check_state(tag);
      end
   endtask

   initial begin
      RESET_N     = 1'b0;
      WRITEENABLE = 1'b0;
      ZERO_IN     = 1'b0;
      IN          = 8'h00;
      INADDRESS   = 3'd0;
      OUT1ADDRESS = 3'd0;
      OUT2ADDRESS = 3'd0;
      model_reset();
      repeat (2) @(negedge CLK);
      sweep("reset_sweep");
      RESET_N = 1'b1;

      // Single write to r2, then idle
      cycle("r2_fwd",  1'b1, 3'd2, 8'h3C, 1'b0, 3'd2, 3'd0);
      chk("r2_fwd_lit", REGOUT1, 8'h3C);
      cycle("r2_arr",  1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 3'd2);
      chk("r2_arr_lit", REGOUT1, 8'h3C);

      // Back-to-back writes to r5
      cycle("r5_a",    1'b1, 3'd5, 8'h11, 1'b0, 3'd5, 3'd5);
      chk("r5_a_lit", REGOUT2, 8'h11);
      cycle("r5_b",    1'b1, 3'd5, 8'hA0, 1'b0, 3'd5, 3'd5);
      chk("r5_b_lit", REGOUT1, 8'hA0);
      cycle("r5_idle", 1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd5);
      chk("r5_idle_lit", REGOUT2, 8'hA0);

      // Consecutive writes to different registers
      cycle("r1_w", 1'b1, 3'd1, 8'h01, 1'b0, 3'd1, 3'd2);
      cycle("r2_w", 1'b1, 3'd2, 8'h02, 1'b0, 3'd1, 3'd2);
      cycle("r3_w", 1'b1, 3'd3, 8'h03, 1'b0, 3'd2, 3'd3);
      cycle("idle", 1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 3'd3);
      sweep("multi_sweep");

      // Zero flag capture and hold
      cycle("zf_set",  1'b1, 3'd4, 8'h00, 1'b1, 3'd4, 3'd0);
      chk("zf_set_lit", {7'd0, ZERO_FLAG}, 8'h01);
      cycle("zf_hold", 1'b0, 3'd0, 8'h00, 1'b0, 3'd4, 3'd0);
      chk("zf_hold_lit", {7'd0, ZERO_FLAG}, 8'h01);

      // Reset while r6 write is pending
      cycle("r6_w", 1'b1, 3'd6, 8'hFF, 1'b0, 3'd6, 3'd6);
      RESET_N = 1'b0;
      #1;
      model_reset();
      check_state("r6_rst");
      chk("r6_rst_lit", REGOUT1, 8'h00);
      cycle("rst_hold2", 1'b1, 3'd6, 8'h77, 1'b1, 3'd6, 3'd6);
      cycle("rst_hold3", 1'b0, 3'd0, 8'h00, 1'b0, 3'd6, 3'd6);
      RESET_N = 1'b1;
      #1;
      check_state("r6_rel");
      sweep("rel_sweep");

      // Randomized traffic with occasional asynchronous reset pulses
      for (int n = 0; n < 400; n++) begin
         logic       we;
         logic [7:0] d;
         logic       z;
         we = ($urandom_range(3) != 0);
         d  = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
         z  = (d == 8'h00) ? 1'b1 : 1'($urandom_range(1));
         cycle("rand", we, 3'($urandom_range(7)), d, z,
               3'($urandom_range(7)), 3'($urandom_range(7)));
         if (n % 16 == 15) sweep("rand_sweep");
         if (n % 97 == 50) begin
            RESET_N = 1'b0;
            #2;
            model_reset();
            check_state("rand_rst");
            RESET_N = 1'b1;
            #1;
            check_state("rand_rel");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
